// File: rtl/sound_store_rx_if.sv
// Bus bundle for sound_store_rx.
//  master : the side that feeds serial data, frame restarts and read addresses
//           (board logic or a testbench).
//  slave  : the receiver itself.
// Signals:
//  rx, frame_rst, rd_addr               driven by master
//  rd_data, wr_addr, bytes_written,
//  word_valid, err_frame, err_parity    driven by slave
`timescale 1ns/1ps
interface sound_store_rx_if #(
    parameter int ADDR_W = 9,
    parameter int DW     = 16,
    parameter int CNT_W  = 14
);
    logic              rx;
    logic              frame_rst;
    logic [ADDR_W-1:0] rd_addr;
    logic [DW-1:0]     rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  bytes_written;
    logic              word_valid;
    logic              err_frame;
    logic              err_parity;

    modport master (
        output rx, frame_rst, rd_addr,
        input  rd_data, wr_addr, bytes_written, word_valid, err_frame, err_parity
    );

    modport slave (
        input  rx, frame_rst, rd_addr,
        output rd_data, wr_addr, bytes_written, word_valid, err_frame, err_parity
    );
endinterface

// File: rtl/sound_store_rx.sv
// sound_store_rx: serial sound-sample receiver.
// UART bytes (8 data bits, LSB first, optional parity, one stop bit) arriving
// on bus.rx are packed little-endian into BYTES_PER_WORD-byte words and written
// into an internal dual-port RAM at an auto-incrementing address. A frame
// restart rewinds the write pointer and the byte counter.
// Ports:
//  clock   system clock
//  reset   asynchronous, active-high, clears all state (RAM contents kept)
//  bus     sound_store_rx_if.slave: rx, frame_rst, rd_addr in;
//          rd_data (1-cycle registered read), wr_addr (fill level),
//          bytes_written, word_valid, err_frame, err_parity out
`timescale 1ns/1ps
module sound_store_rx #(
    parameter int CLKS_PER_BIT   = 48,
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_W         = 9,
    parameter int PARITY         = 0,
    parameter int CNT_W          = 14
) (
    input  logic            clock,
    input  logic            reset,
    sound_store_rx_if.slave bus
);
    localparam int DW    = 8 * BYTES_PER_WORD;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BIW   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(HALF - 1);
    localparam logic [BIW-1:0] IDX_LAST = BIW'(BYTES_PER_WORD - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PAR     = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_WAIT_HI = 3'd5;

    logic              rx_meta_reg;
    logic              rx_s_reg;
    logic [2:0]        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        bit_reg;
    logic [7:0]        shift_reg;
    logic              par_err_reg;
    logic [BIW-1:0]    byte_idx_reg;
    logic [DW-1:0]     word_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [CNT_W-1:0]  bytes_reg;
    logic              word_valid_reg;
    logic              err_frame_reg;
    logic              err_parity_reg;
    logic [DW-1:0]     rd_data_reg;

    logic [DW-1:0]     mem [0:DEPTH-1];

    logic          sample_pt;
    logic          stop_pt;
    logic          byte_ok;
    logic          byte_bad;
    logic          commit;
    logic          par_exp;
    logic [DW-1:0] word_next;

    always_comb begin
        sample_pt = (cnt_reg == CNT_LAST);
        stop_pt   = (state_reg == S_STOP) && sample_pt;
        byte_ok   = stop_pt && rx_s_reg && !par_err_reg;
        byte_bad  = stop_pt && (!rx_s_reg || par_err_reg);
        // frame_rst outranks a commit: the word is dropped, nothing written
        commit    = byte_ok && (byte_idx_reg == IDX_LAST) && !bus.frame_rst;
        // Expected parity bit: even makes the total count of ones even
        par_exp   = (PARITY == 2) ? ~(^shift_reg) : (^shift_reg);
    end

    // Each byte lane takes the incoming byte when it is the lane being filled;
    // word_next is therefore the complete word on the commit cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_next[8*gi +: 8] =
                (byte_ok && (byte_idx_reg == BIW'(gi))) ? shift_reg : word_reg[8*gi +: 8];
        end
    endgenerate

    // Two-flop synchroniser, preset to idle-high so reset cannot fake a start bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Bit-level receive FSM; untouched by frame_rst
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            par_err_reg    <= 1'b0;
            err_frame_reg  <= 1'b0;
            err_parity_reg <= 1'b0;
        end else begin
            err_frame_reg  <= stop_pt && !rx_s_reg;
            err_parity_reg <= stop_pt && rx_s_reg && par_err_reg;
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                    end
                end
                S_START: begin
                    if (rx_s_reg) begin
                        state_reg <= S_IDLE;        // too short: glitch
                    end else if (cnt_reg == CNT_HALF) begin
                        state_reg   <= S_DATA;      // now mid start bit
                        cnt_reg     <= '0;
                        bit_reg     <= '0;
                        par_err_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sample_pt) begin
                        shift_reg[bit_reg] <= rx_s_reg;
                        cnt_reg            <= '0;
                        if (bit_reg == 3'd7) begin
                            state_reg <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_PAR: begin
                    if (sample_pt) begin
                        par_err_reg <= (rx_s_reg != par_exp);
                        cnt_reg     <= '0;
                        state_reg   <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sample_pt) begin
                        cnt_reg   <= '0;
                        state_reg <= rx_s_reg ? S_IDLE : S_WAIT_HI;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    // Line held low past the stop bit: wait for idle before rearming
                    if (rx_s_reg) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Word assembly, write pointer and byte counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            wr_addr_reg    <= '0;
            bytes_reg      <= '0;
            word_valid_reg <= 1'b0;
        end else if (bus.frame_rst) begin
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            wr_addr_reg    <= '0;
            bytes_reg      <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= commit;
            if (byte_bad) begin
                byte_idx_reg <= '0;                 // partial word abandoned
            end else if (byte_ok) begin
                if (!(&bytes_reg)) begin
                    bytes_reg <= bytes_reg + 1'b1;
                end
                word_reg <= word_next;
                if (byte_idx_reg == IDX_LAST) begin
                    byte_idx_reg <= '0;
                    wr_addr_reg  <= wr_addr_reg + 1'b1;     // wraps at depth
                end else begin
                    byte_idx_reg <= byte_idx_reg + 1'b1;
                end
            end
        end
    end

    // Sample RAM: no reset so it maps onto block RAM; read-before-write
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[wr_addr_reg] <= word_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data       = rd_data_reg;
    assign bus.wr_addr       = wr_addr_reg;
    assign bus.bytes_written = bytes_reg;
    assign bus.word_valid    = word_valid_reg;
    assign bus.err_frame     = err_frame_reg;
    assign bus.err_parity    = err_parity_reg;
endmodule

// File: tb/tb_sound_store_rx.sv
`timescale 1ns/1ps
module tb_sound_store_rx;
    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 14;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sound_store_rx_if #(.ADDR_W(AW), .DW(16), .CNT_W(CW)) bus ();

    sound_store_rx #(
        .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2), .ADDR_W(AW), .PARITY(1), .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitors
    int wv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.word_valid) wv_cnt++;
            if (bus.err_frame)  fe_cnt++;
            if (bus.err_parity) pe_cnt++;
        end
    end

    // Reference model: bytes in, words out, expressed as plain arithmetic
    int          m_idx, m_wr, m_bytes;
    logic [15:0] m_part;
    logic [15:0] m_mem [DEPTH];
    bit          m_ok  [DEPTH];
    int          e_wv = 0, e_fe = 0, e_pe = 0;

    function automatic logic even_bit(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic model_clear();
        m_idx = 0; m_part = 0; m_wr = 0; m_bytes = 0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit par_good, input bit stop_good);
        if (!stop_good) begin
            e_fe++; m_idx = 0; m_part = 0;
        end else if (!par_good) begin
            e_pe++; m_idx = 0; m_part = 0;
        end else begin
            if (m_bytes < (1 << CW) - 1) m_bytes++;
            m_part = m_part | (16'(d) << (8 * m_idx));
            if (m_idx == 1) begin
                m_mem[m_wr] = m_part; m_ok[m_wr] = 1;
                m_wr = (m_wr + 1) % DEPTH;
                m_idx = 0; m_part = 0; e_wv++;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        @(negedge clock);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        bus.rx = par_bit;
        repeat (CPB) @(negedge clock);
        bus.rx = stop_bit;
        repeat (CPB) @(negedge clock);
        bus.rx = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, even_bit(d), 1'b1);
        model_byte(d, 1, 1);
    endtask

    task automatic pulse_frame_rst();
        @(negedge clock);
        bus.frame_rst = 1'b1;
        @(negedge clock);
        bus.frame_rst = 1'b0;
        model_clear();
    endtask

    task automatic read_mem(input int a, output logic [15:0] v);
        @(negedge clock);
        bus.rd_addr = AW'(a);
        @(negedge clock);
        v = bus.rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++; if (bus.rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        n_vec++; if (bus.wr_addr !== 2'd0) begin n_err++; $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); end
        n_vec++; if (bus.bytes_written !== 14'd0) begin n_err++; $display("FAIL reset_bytes got %0d want 0", bus.bytes_written); end
        n_vec++; if ({bus.word_valid, bus.err_frame, bus.err_parity} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses got %b want 000", {bus.word_valid, bus.err_frame, bus.err_parity});
        end
        reset = 1'b0;
        model_clear();
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [15:0] v;
        send_good(8'h34);
        send_good(8'h12);
        read_mem(0, v);
        n_vec++; if (v !== 16'h1234) begin n_err++; $display("FAIL basic_ram0 got %h want 1234", v); end
        n_vec++; if (wv_cnt !== 1) begin n_err++; $display("FAIL basic_word_valid got %0d want 1", wv_cnt); end
        n_vec++; if (bus.bytes_written !== 14'd2) begin n_err++; $display("FAIL basic_bytes got %0d want 2", bus.bytes_written); end
        n_vec++; if (bus.wr_addr !== 2'd1) begin n_err++; $display("FAIL basic_wr_addr got %0d want 1", bus.wr_addr); end
        $display("basic: 34,12 -> ram0=%h bytes=%0d wr=%0d", v, bus.bytes_written, bus.wr_addr);
    endtask

    task automatic test_glitch();
        @(negedge clock);
        bus.rx = 1'b0;
        repeat (5) @(negedge clock);
        bus.rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        n_vec++; if (bus.bytes_written !== 14'(m_bytes)) begin n_err++; $display("FAIL glitch_bytes got %0d want %0d", bus.bytes_written, m_bytes); end
        n_vec++; if ({fe_cnt, pe_cnt} !== {e_fe, e_pe}) begin n_err++; $display("FAIL glitch_errs got %0d/%0d want %0d/%0d", fe_cnt, pe_cnt, e_fe, e_pe); end
        $display("glitch: 5-cycle low pulse, bytes=%0d", bus.bytes_written);
    endtask

    task automatic test_frame_err();
        logic [15:0] v;
        int a;
        send_good(8'h34);
        send_frame(8'hAB, even_bit(8'hAB), 1'b0);
        model_byte(8'hAB, 1, 0);
        n_vec++; if (fe_cnt !== e_fe) begin n_err++; $display("FAIL framing_pulse got %0d want %0d", fe_cnt, e_fe); end
        n_vec++; if (bus.bytes_written !== 14'(m_bytes)) begin n_err++; $display("FAIL framing_bytes got %0d want %0d", bus.bytes_written, m_bytes); end
        a = m_wr;
        send_good(8'h78);
        send_good(8'h56);
        read_mem(a, v);
        n_vec++; if (v !== 16'h5678) begin n_err++; $display("FAIL framing_word got %h want 5678", v); end
        $display("frame_err: AB dropped, next word=%h at %0d", v, a);
    endtask

    task automatic test_parity();
        send_frame(8'h03, 1'b1, 1'b1);
        model_byte(8'h03, 0, 1);
        n_vec++; if (pe_cnt !== e_pe) begin n_err++; $display("FAIL parity_pulse got %0d want %0d", pe_cnt, e_pe); end
        n_vec++; if (bus.bytes_written !== 14'(m_bytes)) begin n_err++; $display("FAIL parity_bad_bytes got %0d want %0d", bus.bytes_written, m_bytes); end
        send_frame(8'h03, 1'b0, 1'b1);
        model_byte(8'h03, 1, 1);
        n_vec++; if (bus.bytes_written !== 14'(m_bytes)) begin n_err++; $display("FAIL parity_good_bytes got %0d want %0d", bus.bytes_written, m_bytes); end
        send_good(8'hC7);
        $display("parity: 03/p1 rejected, 03/p0 accepted, bytes=%0d", bus.bytes_written);
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        pulse_frame_rst();
        for (int w = 0; w < 5; w++) begin
            send_good(8'($urandom));
            send_good(8'($urandom));
        end
        n_vec++; if (bus.wr_addr !== 2'd1) begin n_err++; $display("FAIL wrap_wr_addr got %0d want 1", bus.wr_addr); end
        n_vec++; if (bus.bytes_written !== 14'd10) begin n_err++; $display("FAIL wrap_bytes got %0d want 10", bus.bytes_written); end
        for (int a = 0; a < DEPTH; a++) begin
            read_mem(a, v);
            n_vec++; if (v !== m_mem[a]) begin n_err++; $display("FAIL wrap_ram%0d got %h want %h", a, v, m_mem[a]); end
        end
        $display("wrap: 5 words, wr=%0d ram0=%h", bus.wr_addr, m_mem[0]);
    endtask

    task automatic test_frame_rst();
        logic [15:0] v0, v1;
        pulse_frame_rst();
        send_good(8'h11);
        pulse_frame_rst();
        n_vec++; if (bus.wr_addr !== 2'd0) begin n_err++; $display("FAIL frst_wr_addr got %0d want 0", bus.wr_addr); end
        n_vec++; if (bus.bytes_written !== 14'd0) begin n_err++; $display("FAIL frst_bytes got %0d want 0", bus.bytes_written); end
        send_good(8'h22);
        send_good(8'h33);
        read_mem(0, v0);
        n_vec++; if (v0 !== 16'h3322) begin n_err++; $display("FAIL frst_ram0 got %h want 3322", v0); end
        // Read latency: new address shows up only after the next clock edge
        @(negedge clock);
        bus.rd_addr = 2'd1;
        #1;
        n_vec++; if (bus.rd_data !== v0) begin n_err++; $display("FAIL rd_latency_early got %h want %h", bus.rd_data, v0); end
        @(negedge clock);
        v1 = bus.rd_data;
        n_vec++; if (v1 !== m_mem[1]) begin n_err++; $display("FAIL rd_latency_late got %h want %h", v1, m_mem[1]); end
        $display("frame_rst: ram0=%h ram1=%h", v0, v1);
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [15:0] v;
        int kind;
        for (int t = 0; t < 24; t++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 2) pulse_frame_rst();
            if (kind == 0) begin
                send_frame(d, ~even_bit(d), 1'b1);
                model_byte(d, 0, 1);
            end else if (kind == 1) begin
                send_frame(d, 1'($urandom), 1'b0);   // framing outranks parity
                model_byte(d, 1, 0);
            end else begin
                send_good(d);
            end
            n_vec++; if (bus.bytes_written !== 14'(m_bytes) || bus.wr_addr !== AW'(m_wr)) begin
                n_err++;
                $display("FAIL rand%0d_counts got bytes=%0d wr=%0d want bytes=%0d wr=%0d",
                         t, bus.bytes_written, bus.wr_addr, m_bytes, m_wr);
            end
            $display("rand%0d: kind=%0d byte=%h bytes=%0d wr=%0d", t, kind, d, bus.bytes_written, bus.wr_addr);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_mem(a, v);
            if (m_ok[a]) begin
                n_vec++; if (v !== m_mem[a]) begin n_err++; $display("FAIL rand_ram%0d got %h want %h", a, v, m_mem[a]); end
            end
        end
        n_vec++; if ({wv_cnt, fe_cnt, pe_cnt} !== {e_wv, e_fe, e_pe}) begin
            n_err++;
            $display("FAIL rand_pulses got wv=%0d fe=%0d pe=%0d want %0d %0d %0d", wv_cnt, fe_cnt, pe_cnt, e_wv, e_fe, e_pe);
        end
    endtask

    task automatic test_reset_midbyte();
        logic [15:0] v;
        @(negedge clock);
        bus.rx = 1'b0;
        repeat (CPB + 20) @(negedge clock);
        bus.rx = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++; if (bus.bytes_written !== 14'd0 || bus.wr_addr !== 2'd0) begin
            n_err++; $display("FAIL midreset_counts got bytes=%0d wr=%0d want 0 0", bus.bytes_written, bus.wr_addr);
        end
        reset = 1'b0;
        model_clear();
        send_good(8'hCD);
        send_good(8'hAB);
        read_mem(0, v);
        n_vec++; if (v !== 16'hABCD) begin n_err++; $display("FAIL midreset_word got %h want abcd", v); end
        $display("reset_midbyte: resync word=%h", v);
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.frame_rst = 1'b0;
        bus.rd_addr = '0;
        for (int a = 0; a < DEPTH; a++) begin m_mem[a] = 0; m_ok[a] = 0; end
        model_clear();
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_wrap();
        test_frame_rst();
        test_random();
        test_reset_midbyte();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
